// File: rtl/ofc_mem_pkg.sv
// Shared definitions for the per-channel sample memory write/read controllers.
package ofc_mem_pkg;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned QUEUE_W = 6;
    localparam int unsigned N_CH    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wc_state_t;

endpackage

// File: rtl/ring_ptr.sv
// Circular pointer: wrap-increment against a runtime ring depth, with clear and enable.
module ring_ptr #(
    parameter int unsigned W = ofc_mem_pkg::ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] depth,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == depth - W'(1)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/write_control.sv
// Writer-side controller: writes one word per accepted sample into all channel rings,
// groups words into half-packages and drops whole groups when the reader is too far behind.
module write_control #(
    parameter int unsigned ADDR_W  = ofc_mem_pkg::ADDR_W,
    parameter int unsigned LEN_W   = ofc_mem_pkg::LEN_W,
    parameter int unsigned QUEUE_W = ofc_mem_pkg::QUEUE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               live,
    input  logic               live_rising,
    input  logic               din_valid,
    input  logic               half_done,
    input  logic [LEN_W-1:0]   HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0]  MEMORY_DEPTH,
    output logic               wen,
    output logic [ADDR_W-1:0]  waddr,
    output logic               read_start,
    output logic [QUEUE_W-1:0] n_pending,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    localparam int unsigned NE_W = QUEUE_W + 1;

    ofc_mem_pkg::wc_state_t state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [QUEUE_W-1:0] n_pending_d;
    logic               overflow_d;
    logic [15:0]        drop_cnt_d;
    logic               wen_d;
    logic [ADDR_W-1:0]  waddr_d;
    logic               read_start_d;
    logic               ptr_clr;
    logic               ptr_en;
    logic [ADDR_W-1:0]  wr_ptr;
    logic               drop_grp;

    logic [NE_W-1:0]    n_eff;
    logic [15:0]        need_words;
    logic               is_full;
    logic               last_word;

    ring_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .en    (ptr_en),
        .depth (MEMORY_DEPTH),
        .ptr   (wr_ptr)
    );

    // A group completing this cycle is not yet in n_pending, so count it here
    assign n_eff      = NE_W'(n_pending) + NE_W'(read_start);
    assign need_words = (16'(n_eff) + 16'd1) * 16'(HALF_PACKAGE_LENGTH);
    assign is_full    = (need_words > 16'(MEMORY_DEPTH)) ||
                        (n_eff >= NE_W'((1 << QUEUE_W) - 1));
    assign last_word  = (cnt_q == HALF_PACKAGE_LENGTH - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ofc_mem_pkg::IDLE;
            cnt_q      <= '0;
            n_pending  <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            wen        <= 1'b0;
            waddr      <= '0;
            read_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_pending  <= n_pending_d;
            overflow   <= overflow_d;
            drop_cnt   <= drop_cnt_d;
            wen        <= wen_d;
            waddr      <= waddr_d;
            read_start <= read_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_pending_d  = n_pending;
        overflow_d   = overflow;
        drop_cnt_d   = drop_cnt;
        wen_d        = 1'b0;
        waddr_d      = waddr;
        read_start_d = 1'b0;
        ptr_clr      = 1'b0;
        ptr_en       = 1'b0;
        drop_grp     = 1'b0;

        // Completed groups enter the queue, reader releases leave it; coincident events cancel
        if (read_start && !half_done) begin
            n_pending_d = n_pending + QUEUE_W'(1);
        end else if (half_done && !read_start && (n_pending != '0)) begin
            n_pending_d = n_pending - QUEUE_W'(1);
        end

        if (live_rising) begin
            state_d     = live ? ofc_mem_pkg::FILL : ofc_mem_pkg::IDLE;
            cnt_d       = '0;
            n_pending_d = '0;
            overflow_d  = 1'b0;
            drop_cnt_d  = '0;
            ptr_clr     = 1'b1;
        end else begin
            case (state_q)
                ofc_mem_pkg::FILL, ofc_mem_pkg::DROP: begin
                    if (!live) begin
                        state_d = ofc_mem_pkg::IDLE;
                        cnt_d   = '0;
                    end else if (din_valid) begin
                        drop_grp = (state_q == ofc_mem_pkg::DROP);
                        if (cnt_q == '0) begin
                            drop_grp = is_full;
                            state_d  = is_full ? ofc_mem_pkg::DROP : ofc_mem_pkg::FILL;
                            if (is_full) begin
                                overflow_d = 1'b1;
                                if (drop_cnt != 16'hFFFF) begin
                                    drop_cnt_d = drop_cnt + 16'd1;
                                end
                            end
                        end
                        cnt_d = last_word ? '0 : cnt_q + LEN_W'(1);
                        if (!drop_grp) begin
                            wen_d        = 1'b1;
                            waddr_d      = wr_ptr;
                            ptr_en       = 1'b1;
                            read_start_d = last_word;
                        end
                    end
                end
                default: begin
                    state_d = ofc_mem_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_control.sv
// Scoreboard bench for write_control: stimulus queues expected writes/status, a negedge monitor compares.
module tb_write_control;

    logic        clk;
    logic        rst_n;
    logic        live;
    logic        live_rising;
    logic        din_valid;
    logic        half_done;
    logic [9:0]  hpl;
    logic [14:0] mdepth;
    logic        wen;
    logic [14:0] waddr;
    logic        read_start;
    logic [5:0]  n_pending;
    logic        overflow;
    logic [15:0] drop_cnt;

    typedef struct {
        logic [14:0] addr;
        logic        rs;
    } wr_t;

    typedef struct {
        int          kind;   // 0: status, 1: everything zero, 2: write queue drained
        logic [5:0]  np;
        logic        ov;
        logic [15:0] dc;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];
    int  checks = 0;
    int  errors = 0;

    write_control dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .live                (live),
        .live_rising         (live_rising),
        .din_valid           (din_valid),
        .half_done           (half_done),
        .HALF_PACKAGE_LENGTH (hpl),
        .MEMORY_DEPTH        (mdepth),
        .wen                 (wen),
        .waddr               (waddr),
        .read_start          (read_start),
        .n_pending           (n_pending),
        .overflow            (overflow),
        .drop_cnt            (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every comparison happens here
    always @(negedge clk) begin
        wr_t e;
        st_t s;
        if (wen || read_start) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wen=%0b waddr=%0d read_start=%0b, expected no write",
                         wen, waddr, read_start);
            end else begin
                e = wr_q.pop_front();
                if (!wen || waddr !== e.addr || read_start !== e.rs) begin
                    errors++;
                    $display("FAIL write: got wen=%0b waddr=%0d read_start=%0b, expected wen=1 waddr=%0d read_start=%0b",
                             wen, waddr, read_start, e.addr, e.rs);
                end
            end
        end
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            checks++;
            case (s.kind)
                0: if (n_pending !== s.np || overflow !== s.ov || drop_cnt !== s.dc) begin
                    errors++;
                    $display("FAIL status: got n_pending=%0d overflow=%0b drop_cnt=%0d, expected %0d %0b %0d",
                             n_pending, overflow, drop_cnt, s.np, s.ov, s.dc);
                end
                1: if (wen !== 1'b0 || waddr !== 15'd0 || read_start !== 1'b0 || n_pending !== 6'd0 ||
                       overflow !== 1'b0 || drop_cnt !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_zero: got wen=%0b waddr=%0d read_start=%0b n_pending=%0d overflow=%0b drop_cnt=%0d, expected all 0",
                             wen, waddr, read_start, n_pending, overflow, drop_cnt);
                end
                default: if (wr_q.size() != 0) begin
                    errors++;
                    $display("FAIL drained: got %0d writes never seen, expected 0", wr_q.size());
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic pulse_half_done();
        half_done = 1'b1;
        tick();
        half_done = 1'b0;
    endtask

    task automatic pulse_rising(input logic lv);
        live        = lv;
        live_rising = 1'b1;
        tick();
        live_rising = 1'b0;
    endtask

    task automatic exp_wr(input int addr, input logic rs);
        wr_t e;
        e.addr = 15'(addr);
        e.rs   = rs;
        wr_q.push_back(e);
    endtask

    // Consecutive addresses without wrap; read_start on the last one when rs_last
    task automatic exp_run(input int start, input int n, input logic rs_last);
        for (int i = 0; i < n; i++) exp_wr(start + i, rs_last && (i == n - 1));
    endtask

    task automatic exp_st(input int kind, input int np, input logic ov, input int dc);
        st_t s;
        s.kind = kind;
        s.np   = 6'(np);
        s.ov   = ov;
        s.dc   = 16'(dc);
        st_q.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        live        = 1'b0;
        live_rising = 1'b0;
        din_valid   = 1'b0;
        half_done   = 1'b0;
        hpl         = 10'd4;
        mdepth      = 15'd16;
        idle(3);
        exp_st(1, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // Basic: four words at 0..3, read_start with the fourth
        pulse_rising(1'b1);
        exp_run(0, 4, 1'b1);
        sample(4);
        idle(2);
        exp_st(0, 1, 0, 0);
        tick();

        // Second group, then a third whose read_start coincides with half_done
        exp_run(4, 4, 1'b1);
        sample(4);
        idle(2);
        exp_st(0, 2, 0, 0);
        tick();
        exp_run(8, 4, 1'b1);
        sample(4);
        half_done = 1'b1;
        tick();
        half_done = 1'b0;
        idle(1);
        exp_st(0, 2, 0, 0);
        tick();
        pulse_half_done();
        pulse_half_done();
        pulse_half_done();
        idle(1);
        exp_st(0, 0, 0, 0);
        tick();

        // Wrap: depth 10, each group released before the next
        hpl    = 10'd4;
        mdepth = 15'd10;
        pulse_rising(1'b1);
        exp_run(0, 4, 1'b1);
        exp_run(4, 4, 1'b1);
        exp_wr(8, 1'b0);
        exp_wr(9, 1'b0);
        exp_wr(0, 1'b0);
        exp_wr(1, 1'b1);
        for (int g = 0; g < 3; g++) begin
            sample(4);
            idle(1);
            pulse_half_done();
            idle(1);
        end
        exp_st(0, 0, 0, 0);
        tick();

        // Full: fifth group dropped, pointer frozen at 0
        mdepth = 15'd16;
        pulse_rising(1'b1);
        exp_run(0, 4, 1'b1);
        exp_run(4, 4, 1'b1);
        exp_run(8, 4, 1'b1);
        exp_run(12, 4, 1'b1);
        sample(20);
        idle(2);
        exp_st(0, 4, 1, 1);
        tick();
        pulse_half_done();
        idle(1);
        exp_run(0, 4, 1'b1);
        sample(4);
        idle(2);
        exp_st(0, 4, 1, 1);
        tick();

        // Live drop: partial group abandoned, samples ignored until live_rising
        pulse_half_done();
        idle(1);
        exp_run(4, 2, 1'b0);
        sample(2);
        live = 1'b0;
        sample(3);
        idle(2);
        exp_st(0, 3, 1, 1);
        tick();
        live = 1'b1;
        sample(2);
        idle(1);
        exp_st(0, 3, 1, 1);
        tick();
        pulse_rising(1'b1);
        exp_st(0, 0, 0, 0);
        exp_run(0, 4, 1'b1);
        sample(4);
        idle(2);
        exp_st(0, 1, 0, 0);
        tick();

        // Async reset mid-group, between edges
        exp_run(4, 2, 1'b0);
        sample(2);
        idle(1);
        #2;
        rst_n = 1'b0;
        exp_st(1, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        idle(1);
        pulse_rising(1'b1);
        exp_run(0, 4, 1'b1);
        sample(4);
        idle(2);
        exp_st(0, 1, 0, 0);
        tick();

        exp_st(2, 0, 0, 0);
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
